// File: rtl/wishbone_ram_slave_if.sv
// Pipelined Wishbone B4 bus bundle between one master port and one RAM slave.
//
// Handshake: a request transfers on a rising clock edge where cyc=1, stb=1 and
// stall=0. The master holds stb/we/addr/sel/data_m stable while stall=1. Each
// transferred request is terminated by exactly one single-cycle ack or err
// pulse. data_s is meaningful only while ack=1. stb is ignored while cyc=0.
// Dropping cyc abandons any request that has not been terminated yet.
interface wishbone_ram_slave_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data_m;
    logic [31:0] data_s;
    logic        ack;
    logic        err;
    logic        stall;

    modport master (
        output cyc, stb, we, addr, sel, data_m,
        input  data_s, ack, err, stall
    );

    modport slave (
        input  cyc, stb, we, addr, sel, data_m,
        output data_s, ack, err, stall
    );
endinterface

// File: rtl/wishbone_ram_slave.sv
// Pipelined Wishbone B4 RAM slave: decodes its own address window, does
// byte-lane writes and registered reads, and can add a fixed number of
// wait states between accepting a request and terminating it.
module wishbone_ram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    wishbone_ram_slave_if.slave bus,
    output logic [1:0]          dbg_state
);
    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [31:0] WIN_BYTES = 32'(DEPTH * 4);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;

    logic        resp_err;
    logic [31:0] resp_data;

    logic [31:0] mem [DEPTH];

    logic        stall_int;
    logic        accept;
    logic        legal;
    logic [31:0] off;
    logic [AW-1:0] idx;

    // Only the wait phase stalls; the interconnect ORs stall across slaves.
    assign stall_int = (state == S_WAIT);
    assign accept    = bus.cyc & bus.stb & ~stall_int;

    // Window decode: offset wraps, so addresses below the base land far out of range.
    assign off   = bus.addr - BASE_ADDR;
    assign legal = (off < WIN_BYTES) && (bus.addr[1:0] == 2'b00);
    assign idx   = off[AW+1:2];

    // Byte-lane write commits at the acceptance edge, independent of the response.
    always_ff @(posedge clk_i) begin
        if (accept && legal && bus.we) begin
            for (int n = 0; n < 4; n++) begin
                if (bus.sel[n]) begin
                    mem[idx][8*n +: 8] <= bus.data_m[8*n +: 8];
                end
            end
        end
    end

    // Capture the response kind and read word when a request is accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_err  <= 1'b0;
            resp_data <= '0;
        end else if (accept) begin
            resp_err  <= ~legal;
            resp_data <= (legal && !bus.we) ? mem[idx] : '0;
        end
    end

    // State and wait counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: accept, optionally wait, then respond once.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE, S_RESP: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = S_RESP;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = WAIT_INIT;
                    end
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!bus.cyc) begin
                    // Master abandoned the cycle: drop the pending response.
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == 4'd1) begin
                    state_nxt = S_RESP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Termination outputs are decoded from registered state only.
    assign bus.stall  = stall_int;
    assign bus.ack    = (state == S_RESP) & ~resp_err;
    assign bus.err    = (state == S_RESP) &  resp_err;
    assign bus.data_s = bus.ack ? resp_data : '0;
    assign dbg_state  = state;
endmodule

// File: tb/tb_wishbone_ram_slave.sv
// Bench for wishbone_ram_slave: two instances (0 and 3 wait states) share the
// request signals; cyc is steered to the selected one. A transaction-level
// model predicts every cycle's ack/err/stall/data_s.
module tb_wishbone_ram_slave;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 1024;
    localparam int          EW    = 67;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared request drive ----------------
    logic        dsel  = 1'b0;
    logic        cyc   = 1'b0;
    logic        stb   = 1'b0;
    logic        we    = 1'b0;
    logic [31:0] addr  = '0;
    logic [3:0]  sel   = '0;
    logic [31:0] wdata = '0;

    wishbone_ram_slave_if bus0 ();
    wishbone_ram_slave_if bus3 ();
    logic [1:0] dbg0;
    logic [1:0] dbg3;

    assign bus0.cyc    = cyc & ~dsel;
    assign bus0.stb    = stb;
    assign bus0.we     = we;
    assign bus0.addr   = addr;
    assign bus0.sel    = sel;
    assign bus0.data_m = wdata;
    assign bus3.cyc    = cyc & dsel;
    assign bus3.stb    = stb;
    assign bus3.we     = we;
    assign bus3.addr   = addr;
    assign bus3.sel    = sel;
    assign bus3.data_m = wdata;

    wishbone_ram_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus0.slave), .dbg_state(dbg0));
    wishbone_ram_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus3.slave), .dbg_state(dbg3));

    logic        r_ack;
    logic        r_err;
    logic        r_stall;
    logic [31:0] r_data;
    logic [1:0]  r_dbg;
    assign r_ack   = dsel ? bus3.ack    : bus0.ack;
    assign r_err   = dsel ? bus3.err    : bus0.err;
    assign r_stall = dsel ? bus3.stall  : bus0.stall;
    assign r_data  = dsel ? bus3.data_s : bus0.data_s;
    assign r_dbg   = dsel ? dbg3        : dbg0;

    // ---------------- reference model / scoreboard ----------------
    // exp_q entry: {resp_cycle[31:0], is_read, is_err, check_data, data[31:0]}
    logic [EW-1:0] exp_q[$];
    logic [31:0]   m_mem   [2][DEPTH];
    logic [3:0]    m_known [2][DEPTH];
    int            cyc_cnt    = 0;
    int            n_tests    = 0;
    int            n_fail     = 0;
    logic [31:0]   last_rdata = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d, dut %0d)", tag, got, exp, cyc_cnt, dsel);
        end
    endtask

    function automatic int wait_of();
        return dsel ? 3 : 0;
    endfunction

    // A request is still waiting if its response cycle lies in the future.
    function automatic bit model_stall();
        foreach (exp_q[i]) begin
            if (int'(exp_q[i][66:35]) > cyc_cnt) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_accept();
        logic [31:0] off;
        int          idx;
        bit          ok;
        bit          chk;
        logic [31:0] d;
        off = addr - BASE;
        ok  = (off < 32'(DEPTH * 4)) && (addr[1:0] == 2'b00);
        idx = ok ? int'(off >> 2) : 0;
        d   = '0;
        chk = 1'b1;
        if (ok && we) begin
            for (int n = 0; n < 4; n++) begin
                if (sel[n]) begin
                    m_mem[dsel][idx][8*n +: 8] = wdata[8*n +: 8];
                    m_known[dsel][idx][n]      = 1'b1;
                end
            end
        end else if (ok) begin
            d   = m_mem[dsel][idx];
            chk = (m_known[dsel][idx] == 4'hF);
        end
        exp_q.push_back({32'(cyc_cnt + 1 + wait_of()), ok && !we, !ok, chk, d});
    endtask

    // One clock: apply model at the edge, then check every output.
    task automatic step();
        logic [EW-1:0] e;
        bit            x_ack;
        bit            x_err;
        bit            x_rd;
        bit            chk;
        logic [31:0]   x_data;
        if (!cyc) begin
            while (exp_q.size() > 0 && int'(exp_q[$][66:35]) > cyc_cnt) void'(exp_q.pop_back());
        end else if (stb && !model_stall()) begin
            model_accept();
        end
        @(posedge clk);
        cyc_cnt++;
        @(negedge clk);
        x_ack = 1'b0; x_err = 1'b0; x_rd = 1'b0; chk = 1'b1; x_data = '0;
        if (exp_q.size() > 0 && int'(exp_q[0][66:35]) == cyc_cnt) begin
            e      = exp_q.pop_front();
            x_rd   = e[34];
            x_err  = e[33];
            x_ack  = !e[33];
            chk    = e[32];
            x_data = e[31:0];
        end
        check_eq("ack", 32'(r_ack), 32'(x_ack));
        check_eq("err", 32'(r_err), 32'(x_err));
        check_eq("stall", 32'(r_stall), 32'(model_stall()));
        if (chk) check_eq("data_s", r_data, x_data);
        if (x_rd && r_ack) last_rdata = r_data;
    endtask

    // ---------------- driver tasks ----------------
    task automatic xfer(input bit w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        bit acc;
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; sel = s; wdata = d;
        for (int k = 0; k < 40; k++) begin
            acc = !model_stall();
            step();
            if (acc) break;
        end
        stb = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && exp_q.size() > 0; k++) step();
        cyc = 1'b0;
        step();
    endtask

    task automatic rand_xfer();
        int          k;
        logic [31:0] a;
        k = $urandom_range(0, 9);
        if (k < 6)       a = BASE + 32'(4 * $urandom_range(0, 15));
        else if (k == 6) a = BASE + 32'h0000_0FFC;
        else if (k == 7) a = BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 3));
        else if (k == 8) a = BASE - 32'd4;
        else             a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
        xfer(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence and final report ----------------
    initial begin
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++) m_known[d][i] = 4'h0;

        // Reset state of both instances.
        step();
        step();
        check_eq("rst_state0", 32'(dbg0), 32'd0);
        check_eq("rst_state3", 32'(dbg3), 32'd0);
        check_eq("rst_outs3", {28'd0, bus3.ack, bus3.err, bus3.stall, |bus3.data_s}, 32'd0);
        rst_n = 1'b1;
        step();

        // Zero wait states: write then read back-to-back.
        dsel = 1'b0;
        xfer(1'b1, 32'h1000_0008, 4'hF, 32'hDEAD_BEEF);
        xfer(1'b0, 32'h1000_0008, 4'hF, 32'h0);
        drain();
        check_eq("rd_deadbeef", last_rdata, 32'hDEAD_BEEF);

        // Byte lanes, and a sel=0 write that must change nothing.
        xfer(1'b1, 32'h1000_0008, 4'b0101, 32'h1122_3344);
        xfer(1'b0, 32'h1000_0008, 4'hF, 32'h0);
        drain();
        check_eq("byte_lanes", last_rdata, 32'hDE22_BE44);
        xfer(1'b1, 32'h1000_0008, 4'h0, 32'hFFFF_FFFF);
        xfer(1'b0, 32'h1000_0008, 4'hF, 32'h0);
        drain();
        check_eq("sel_zero", last_rdata, 32'hDE22_BE44);

        // Errors: out of range, misaligned, below base; last word of window.
        xfer(1'b1, 32'h1000_0000, 4'hF, 32'h0BAD_F00D);
        xfer(1'b0, 32'h1000_1000, 4'hF, 32'h0);
        xfer(1'b1, 32'h1000_0002, 4'hF, 32'hFFFF_FFFF);
        xfer(1'b0, 32'h0FFF_FFFC, 4'hF, 32'h0);
        xfer(1'b0, 32'h1000_0000, 4'hF, 32'h0);
        drain();
        check_eq("misalign_nowrite", last_rdata, 32'h0BAD_F00D);
        xfer(1'b1, 32'h1000_0FFC, 4'hF, 32'hA5A5_5A5A);
        xfer(1'b0, 32'h1000_0FFC, 4'hF, 32'h0);
        drain();
        check_eq("last_word", last_rdata, 32'hA5A5_5A5A);

        // Back-to-back: four writes, four reads, stb held continuously.
        for (int i = 0; i < 4; i++) xfer(1'b1, BASE + 32'(4 * i), 4'hF, $urandom());
        for (int i = 0; i < 4; i++) xfer(1'b0, BASE + 32'(4 * i), 4'hF, 32'h0);
        drain();

        // Three wait states: second request held against stall.
        dsel = 1'b1;
        xfer(1'b1, BASE + 32'd20, 4'hF, 32'hCAFE_0005);
        xfer(1'b0, BASE + 32'd20, 4'hF, 32'h0);
        drain();
        check_eq("wait_rd", last_rdata, 32'hCAFE_0005);

        // Abort: cyc dropped one cycle after acceptance; the write still sticks.
        xfer(1'b1, BASE + 32'd24, 4'hF, 32'h1234_5678);
        cyc = 1'b0;
        step();
        check_eq("abort_idle", 32'(r_dbg), 32'd0);
        for (int i = 0; i < 4; i++) step();
        xfer(1'b0, BASE + 32'd24, 4'hF, 32'h0);
        drain();
        check_eq("abort_wr_kept", last_rdata, 32'h1234_5678);

        // Reset during the wait phase, then a fresh request.
        xfer(1'b0, BASE + 32'd20, 4'hF, 32'h0);
        step();
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_outs", {29'd0, r_ack, r_err, r_stall}, 32'd0);
        check_eq("rst_mid_state", 32'(r_dbg), 32'd0);
        exp_q.delete();
        cyc = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        xfer(1'b0, BASE + 32'd20, 4'hF, 32'h0);
        drain();
        check_eq("post_rst_rd", last_rdata, 32'hCAFE_0005);

        // Randomized traffic on both instances, with gaps and cyc drops.
        for (int d = 0; d < 2; d++) begin
            dsel = 1'(d);
            for (int t = 0; t < 150; t++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 15) begin
                    cyc = 1'b0;
                    stb = 1'($urandom_range(0, 1));
                    step();
                    if ($urandom_range(0, 1) == 1) step();
                    stb = 1'b0;
                end else if (r < 35) begin
                    cyc = 1'b1;
                    stb = 1'b0;
                    step();
                end
                rand_xfer();
            end
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wishbone_ram_slave.md
Name: wishbone_ram_slave

Overview:
- Pipelined Wishbone B4 slave (responder) with an internal word-wide RAM.
- It is the far end of the shared-bus interconnect and attaches to one slave port of that interconnect.
- It decodes its own window, performs byte-lane writes and registered reads, and can insert programmable wait states.
- It returns ack or err exactly once per accepted request.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte base address of the window; must be DEPTH*4 aligned.
- DEPTH, 1024: number of 32-bit words; must be a power of 2, minimum 2.
- WAIT_CYCLES, 0: extra stall cycles inserted between acceptance and response, range 0..15.

Ports:
- clk_i  input  1  bus clock; all logic is on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- cyc  input  1  bus cycle active.
- stb  input  1  request strobe.
- we  input  1  1 = write, 0 = read.
- addr  input  32  byte address.
- sel  input  4  byte-lane enables; sel[n] covers data bits [8n+7:8n].
- data_m  input  32  write data from the master.
- data_s  output  32  read data; valid only while ack=1.
- ack  output  1  successful-termination pulse.
- err  output  1  error-termination pulse.
- stall  output  1  request not accepted this cycle; combinational.

Behaviour:
- Reset (async assert, sync release): state=IDLE, wait counter=0, ack=0, err=0, data_s=0, stall=0. RAM contents are not reset.
- Acceptance: a request is accepted on a rising edge where cyc=1, stb=1 and stall=0. Exactly one ack or err follows each accepted request.
- Decode at acceptance: off = addr - BASE_ADDR (32-bit unsigned wrap).
  - Request is in range when off < DEPTH*4 and addr[1:0]==0.
  - Word index = off[$clog2(DEPTH)+1:2].
- Legal write: at the acceptance edge, for each set sel[n], RAM[idx] byte n <= data_m byte n. When sel==0 nothing is written, but ack is still returned.
- Legal read: at the acceptance edge, the full RAM[idx] word is latched into a response register; sel is ignored for reads.
- Illegal request (out of range or misaligned): no RAM write, response is err instead of ack, data_s=0.
- State machine:
  - IDLE: stall=0, ack=0, err=0. On acceptance, go to RESP if WAIT_CYCLES==0; otherwise go to WAIT with cnt=WAIT_CYCLES.
  - WAIT: stall=1. cnt decrements each cycle; when cnt==1, go to RESP.
  - RESP: ack or err is high for exactly one cycle; data_s = latched word on a read ack, else 0. stall=0, so a new acceptance in the same cycle goes to RESP (WAIT_CYCLES==0) or WAIT; with no acceptance, go to IDLE.
- Latency: ack/err is asserted (1 + WAIT_CYCLES) cycles after the acceptance edge. With WAIT_CYCLES==0, throughput is one request per cycle with stall held at 0.
- stall is never asserted in IDLE or RESP; only WAIT drives it. The interconnect ORs the stall outputs of all slaves, so stall must stay 0 whenever this slave is not busy.
- Abort: if cyc falls while in WAIT, or in the cycle before RESP, the state returns to IDLE at the next edge and no ack/err is issued. A write already committed at acceptance remains committed.
- ack and err are never high in the same cycle. data_s is 0 whenever ack is 0.
- stb with cyc=0 is ignored.
- Reset asserted mid-transaction: outputs clear immediately; the pending response is dropped.

Test Plan:
- Write then read, WAIT_CYCLES=0, BASE_ADDR=32'h1000_0000: write 32'hDEAD_BEEF to 32'h1000_0008 with sel=4'hF -> ack 1 cycle later, stall stays 0. Read the same address -> next cycle ack=1, data_s=32'hDEAD_BEEF.
- Byte lanes: over a word holding 32'hDEAD_BEEF, write 32'h1122_3344 with sel=4'b0101 -> a subsequent read returns 32'hDE22_BE44.
- Errors: read 32'h1000_1000 (out of range, DEPTH=1024) -> err=1, ack=0, data_s=0. Write to 32'h1000_0002 (misaligned) -> err=1, and the RAM word at 32'h1000_0000 is unchanged.
- Wait states, WAIT_CYCLES=3: accept a read at edge T -> stall=1 during the 3 cycles after T, ack at T+4. A second stb held high during those cycles is accepted only when stall=0.
- Back-to-back, WAIT_CYCLES=0: 4 consecutive reads of words 0..3 with stb high for 4 cycles -> 4 consecutive ack cycles with the data in order, and stall=0 throughout.
- Abort and reset: WAIT_CYCLES=3, drop cyc one cycle after acceptance -> no ack/err, state returns to IDLE. Assert rst_ni=0 during WAIT -> ack=err=stall=0 immediately, and a fresh request after release completes normally.
